idac_segment_decoder: RTL and testbench
=======================================

IDAC_SEGMENT_DECODER -- requirements
Module: idac_segment_decoder

Interface
REQ-001 Parameter CODE_W, default 11: input code width in bits.
REQ-002 Parameter N_THERM, default 17: number of thermometric unit cells.
REQ-003 Parameter N_BIN, default 6: number of binary-weighted cells, excluding the redundant LSB cell.
REQ-004 Parameter WARMUP_CYC, default 8: clkin cycles held in WARMUP after power-up.
REQ-005 Port clkin, in, 1: sole clock; this is the distributed clock, and all logic is rising-edge.
REQ-006 Port rst, in, 1: reset, synchronous and active-high.
REQ-007 Port pdb, in, 1: power-down negate; 0 means powered down.
REQ-008 Port code_in, in, CODE_W: unsigned DAC code.
REQ-009 Port code_valid, in, 1: code_in is valid this cycle.
REQ-010 Port code_ready, out, 1: decoder accepts a code this cycle.
REQ-011 Port red_en, in, 1: enables the redundant LSB cell.
REQ-012 Port therm_sel / therm_selb, out, N_THERM each: thermometric cell select and its complement.
REQ-013 Port bin_sel / bin_selb, out, N_BIN each: binary cell select and its complement.
REQ-014 Port bin0_red_sel / bin0_red_selb, out, 1 each: redundant LSB cell select and its complement.
REQ-015 Port active, out, 1: FSM is in ACTIVE.
REQ-016 Port sat_flag, out, 1: the code currently at the outputs was clipped.
REQ-017 Port sat_cnt, out, 8: saturating count of clipped codes.

Function
REQ-018 FSM states SHALL be OFF, WARMUP and ACTIVE.
REQ-019 OFF SHALL go to WARMUP when pdb=1; WARMUP SHALL go to ACTIVE after exactly WARMUP_CYC cycles; WARMUP and ACTIVE SHALL go to OFF on the cycle after pdb=0 is sampled.
REQ-020 In OFF, all sel and selb outputs SHALL be 0 and code_ready SHALL be 0.
REQ-021 In WARMUP, outputs SHALL show code 0 (all sel=0, all selb=1) and code_ready SHALL be 0.
REQ-022 code_ready SHALL be 1 only in ACTIVE; a code is accepted on a cycle with code_valid=1 and code_ready=1.
REQ-023 Full scale FS SHALL equal N_THERM*2^N_BIN + 2^N_BIN - 1 (1151 at defaults); an accepted code above FS SHALL be clipped to FS.
REQ-024 Stage 1 SHALL register the clipped code and its sat bit; stage 2 SHALL register the decoded outputs.
REQ-025 Outputs SHALL update exactly 2 cycles after acceptance, together with sat_flag for that code.
REQ-026 Decode: t = code[CODE_W-1:N_BIN]; therm_sel[i] = 1 for i < t (lowest indices fill first).
REQ-027 Decode: bin_sel = code[N_BIN-1:0].
REQ-028 bin0_red_sel SHALL equal bin_sel[0] AND red_en.
REQ-029 Every selb output SHALL be the bitwise complement of its sel output, except in OFF, where both are 0.
REQ-030 With no new acceptance, outputs SHALL hold their last decoded value.
REQ-031 Back-to-back acceptance SHALL sustain one code per cycle.
REQ-032 sat_cnt SHALL increment on each clipped acceptance and hold at 255.
REQ-033 A pdb fall SHALL flush both pipeline stages, so no in-flight code reaches the outputs.
REQ-034 On return to ACTIVE, outputs SHALL read code 0 until the first new code emerges from the pipeline.

Reset
REQ-035 rst=1 SHALL force OFF, with every output 0, code_ready=0, sat_flag=0, sat_cnt=0 and the pipeline cleared; rst SHALL take priority over pdb.
REQ-036 After rst is released with pdb=1, the block SHALL enter WARMUP on the next cycle.
REQ-037 rst asserted mid-stream SHALL discard in-flight codes.

Verification
REQ-038 Power-up: rst high 3 cycles, then pdb=1 -> active rises after 1+8 cycles; outputs show code 0 throughout WARMUP.
REQ-039 Decode: code 0x247 (583), red_en=1 -> 2 cycles later therm_sel=0x1FF, bin_sel=0x07, bin0_red_sel=1, selb complements.
REQ-040 Saturation: code 2047 -> therm_sel=0x1FFFF, bin_sel=0x3F, sat_flag=1, sat_cnt=1; after 300 clipped codes, sat_cnt=255.
REQ-041 Streaming: codes 0..1151 applied back-to-back -> each appears exactly 2 cycles later, with no gaps and no duplicates.
REQ-042 Power-down: pdb=0 one cycle after accepting code 1000 -> code 1000 never appears, and all sel and selb are 0 in OFF.
REQ-043 Backpressure: code_valid=1 held during WARMUP -> nothing is accepted; the first acceptance is on the first ACTIVE cycle.

Source files
------------

// File: rtl/idac_segment_decoder.sv
// Segmented current-DAC decoder: a power-state FSM (OFF/WARMUP/ACTIVE) gates
// a two-stage pipeline. Stage 1 holds the clipped code and its saturation bit;
// stage 2 holds the thermometer and binary selects driven to the cell array.
module idac_segment_decoder #(
   parameter int unsigned CODE_W     = 11,
   parameter int unsigned N_THERM    = 17,
   parameter int unsigned N_BIN      = 6,
   parameter int unsigned WARMUP_CYC = 8
) (
   input  logic               clkin,
   input  logic               rst,
   input  logic               pdb,
   input  logic [CODE_W-1:0]  code_in,
   input  logic               code_valid,
   output logic               code_ready,
   input  logic               red_en,
   output logic [N_THERM-1:0] therm_sel,
   output logic [N_THERM-1:0] therm_selb,
   output logic [N_BIN-1:0]   bin_sel,
   output logic [N_BIN-1:0]   bin_selb,
   output logic               bin0_red_sel,
   output logic               bin0_red_selb,
   output logic               active,
   output logic               sat_flag,
   output logic [7:0]         sat_cnt
);

   localparam int unsigned       FS        = N_THERM * (2 ** N_BIN) + (2 ** N_BIN) - 1;
   localparam logic [CODE_W-1:0] FS_CODE   = CODE_W'(FS);
   localparam int unsigned       CNT_W     = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
   localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP_CYC - 1);
   localparam int unsigned       T_W       = CODE_W - N_BIN;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_WARMUP,
      ST_ACTIVE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   warm_cnt_q, warm_cnt_d;
   logic               s1_vld_q, s1_vld_d;
   logic [CODE_W-1:0]  s1_code_q, s1_code_d;
   logic               s1_sat_q, s1_sat_d;
   logic [N_THERM-1:0] therm_q, therm_d;
   logic [N_BIN-1:0]   bin_q, bin_d;
   logic               sat_flag_q, sat_flag_d;
   logic [7:0]         sat_cnt_q, sat_cnt_d;

   logic               accept;
   logic               clip;
   logic               is_off;
   logic [T_W-1:0]     t_code;
   logic [N_THERM-1:0] therm_dec;

   assign code_ready = (state_q == ST_ACTIVE);
   assign active     = (state_q == ST_ACTIVE);
   assign is_off     = (state_q == ST_OFF);
   assign accept     = code_valid & code_ready;

   // Power-state sequencing: warm-up counts WARMUP_CYC cycles; pdb low drops to OFF.
   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      case (state_q)
         ST_OFF: begin
            if (pdb) begin
               state_d    = ST_WARMUP;
               warm_cnt_d = '0;
            end
         end
         ST_WARMUP: begin
            if (!pdb) begin
               state_d = ST_OFF;
            end else if (warm_cnt_q == WARM_LAST) begin
               state_d = ST_ACTIVE;
            end else begin
               warm_cnt_d = warm_cnt_q + 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!pdb) begin
               state_d = ST_OFF;
            end
         end
         default: state_d = ST_OFF;
      endcase
   end

   // Clip, pipeline and decode; pdb low flushes both stages back to code 0.
   always_comb begin
      clip       = (code_in > FS_CODE);
      t_code     = s1_code_q[CODE_W-1:N_BIN];
      therm_dec  = '0;
      for (int unsigned i = 0; i < N_THERM; i++) begin
         therm_dec[i] = (i < 32'(t_code));
      end

      s1_vld_d   = accept & pdb;
      s1_code_d  = s1_code_q;
      s1_sat_d   = s1_sat_q;
      therm_d    = therm_q;
      bin_d      = bin_q;
      sat_flag_d = sat_flag_q;
      sat_cnt_d  = sat_cnt_q;

      if (accept) begin
         s1_code_d = clip ? FS_CODE : code_in;
         s1_sat_d  = clip;
         if (clip && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
         end
      end

      if (s1_vld_q) begin
         therm_d    = therm_dec;
         bin_d      = s1_code_q[N_BIN-1:0];
         sat_flag_d = s1_sat_q;
      end

      if (!pdb) begin
         s1_code_d  = '0;
         s1_sat_d   = 1'b0;
         therm_d    = '0;
         bin_d      = '0;
         sat_flag_d = 1'b0;
      end
   end

   // State and pipeline registers with synchronous reset.
   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q    <= ST_OFF;
         warm_cnt_q <= '0;
         s1_vld_q   <= 1'b0;
         s1_code_q  <= '0;
         s1_sat_q   <= 1'b0;
         therm_q    <= '0;
         bin_q      <= '0;
         sat_flag_q <= 1'b0;
         sat_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
         s1_vld_q   <= s1_vld_d;
         s1_code_q  <= s1_code_d;
         s1_sat_q   <= s1_sat_d;
         therm_q    <= therm_d;
         bin_q      <= bin_d;
         sat_flag_q <= sat_flag_d;
         sat_cnt_q  <= sat_cnt_d;
      end
   end

   // Cell drive: complements everywhere except OFF, where both rails are low.
   always_comb begin
      therm_sel     = is_off ? '0 : therm_q;
      therm_selb    = is_off ? '0 : ~therm_q;
      bin_sel       = is_off ? '0 : bin_q;
      bin_selb      = is_off ? '0 : ~bin_q;
      bin0_red_sel  = ~is_off & bin_q[0] & red_en;
      bin0_red_selb = ~is_off & ~(bin_q[0] & red_en);
      sat_flag      = sat_flag_q;
      sat_cnt       = sat_cnt_q;
   end

endmodule

// File: tb/tb_idac_segment_decoder.sv
// Scoreboard bench for idac_segment_decoder: a reference model pushes expected
// codes into a queue with their due cycle; a monitor pops and compares.
module tb_idac_segment_decoder;

   localparam int unsigned CODE_W     = 11;
   localparam int unsigned N_THERM    = 17;
   localparam int unsigned N_BIN      = 6;
   localparam int unsigned WARMUP_CYC = 8;
   localparam int          FS         = N_THERM * (1 << N_BIN) + (1 << N_BIN) - 1;
   localparam int          MAXC       = (1 << CODE_W) - 1;

   logic               clkin = 1'b0;
   logic               rst, pdb, code_valid, red_en;
   logic [CODE_W-1:0]  code_in;
   logic               code_ready, bin0_red_sel, bin0_red_selb, active, sat_flag;
   logic [N_THERM-1:0] therm_sel, therm_selb;
   logic [N_BIN-1:0]   bin_sel, bin_selb;
   logic [7:0]         sat_cnt;

   always #5 clkin = ~clkin;

   idac_segment_decoder #(
      .CODE_W(CODE_W), .N_THERM(N_THERM), .N_BIN(N_BIN), .WARMUP_CYC(WARMUP_CYC)
   ) dut (
      .clkin(clkin), .rst(rst), .pdb(pdb), .code_in(code_in),
      .code_valid(code_valid), .code_ready(code_ready), .red_en(red_en),
      .therm_sel(therm_sel), .therm_selb(therm_selb),
      .bin_sel(bin_sel), .bin_selb(bin_selb),
      .bin0_red_sel(bin0_red_sel), .bin0_red_selb(bin0_red_selb),
      .active(active), .sat_flag(sat_flag), .sat_cnt(sat_cnt)
   );

   typedef struct {
      int due;
      int code;
      bit sat;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   pwr    = 0;   // cycles since power-up began; 0 = off
   int   m_sat  = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: evaluates each clock edge from the sampled inputs.
   initial begin
      exp_t e;
      bit   acc;
      forever begin
         @(posedge clkin);
         acc = code_valid && (pwr > int'(WARMUP_CYC));
         cyc++;
         if (rst) begin
            pwr   = 0;
            m_sat = 0;
            sb.delete();
            e = '{cyc, 0, 1'b0};
            sb.push_back(e);
         end else begin
            if (acc && int'(code_in) > FS && m_sat < 255) m_sat++;
            if (!pdb) begin
               pwr = 0;
               sb.delete();
               e = '{cyc, 0, 1'b0};
               sb.push_back(e);
            end else begin
               if (acc) begin
                  e.due  = cyc + 1;
                  e.sat  = (int'(code_in) > FS);
                  e.code = e.sat ? FS : int'(code_in);
                  sb.push_back(e);
               end
               if (pwr < 100000) pwr++;
            end
         end
      end
   end

   // Monitor: retires due entries, then checks every output against expectation.
   initial begin
      exp_t        e;
      int          exp_code;
      bit          exp_sat;
      bit          off;
      int          t;
      logic [63:0] th, thb, bn, bnb, rd, rdb;
      exp_code = 0;
      exp_sat  = 1'b0;
      forever begin
         @(posedge clkin);
         #1;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            exp_code = e.code;
            exp_sat  = e.sat;
         end
         off = (pwr == 0);
         t   = exp_code / (1 << N_BIN);
         th  = off ? 64'd0 : ((64'd1 << t) - 64'd1);
         thb = off ? 64'd0 : (~th & ((64'd1 << N_THERM) - 64'd1));
         bn  = off ? 64'd0 : 64'(exp_code % (1 << N_BIN));
         bnb = off ? 64'd0 : (~bn & ((64'd1 << N_BIN) - 64'd1));
         rd  = off ? 64'd0 : 64'(bn[0] & red_en);
         rdb = off ? 64'd0 : 64'(!(bn[0] & red_en));
         check("active",        64'(active),        64'(pwr > int'(WARMUP_CYC)));
         check("code_ready",    64'(code_ready),    64'(pwr > int'(WARMUP_CYC)));
         check("therm_sel",     64'(therm_sel),     th);
         check("therm_selb",    64'(therm_selb),    thb);
         check("bin_sel",       64'(bin_sel),       bn);
         check("bin_selb",      64'(bin_selb),      bnb);
         check("bin0_red_sel",  64'(bin0_red_sel),  rd);
         check("bin0_red_selb", 64'(bin0_red_selb), rdb);
         check("sat_flag",      64'(sat_flag),      64'(exp_sat));
         check("sat_cnt",       64'(sat_cnt),       64'(m_sat));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic step(input bit v, input int code, input bit pd, input bit r);
      code_valid = v;
      code_in    = CODE_W'(code);
      pdb        = pd;
      rst        = r;
      @(negedge clkin);
   endtask

   task automatic rand_cycles(input int n, input int pd_drop);
      for (int i = 0; i < n; i++) begin
         red_en = 1'($urandom_range(0, 1));
         step(($urandom_range(0, 9) < 7), int'($urandom_range(0, MAXC)),
              (pd_drop == 0) || ($urandom_range(0, pd_drop - 1) != 0), 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1; pdb = 1'b0; code_valid = 1'b0; code_in = '0; red_en = 1'b1;
      @(negedge clkin);
      // Power-up with a code offered throughout warm-up
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      for (int i = 0; i < 12; i++) step(1, 583, 1, 0);
      step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
      // Full-scale clip, then saturate the clip counter
      step(1, 2047, 1, 0);
      step(0, 0, 1, 0); step(0, 0, 1, 0);
      for (int i = 0; i < 300; i++) step(1, int'($urandom_range(FS + 1, MAXC)), 1, 0);
      step(0, 0, 1, 0); step(0, 0, 1, 0);
      // Back-to-back stream across the full in-range code space
      for (int c = 0; c <= FS; c++) begin
         red_en = 1'($urandom_range(0, 1));
         step(1, c, 1, 0);
      end
      step(0, 0, 1, 0); step(0, 0, 1, 0);
      rand_cycles(300, 0);
      // Power-down right behind an accepted code
      red_en = 1'b1;
      step(1, 1000, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
      rand_cycles(50, 0);
      // Reset in the middle of a stream
      for (int i = 0; i < 6; i++) step(1, int'($urandom_range(0, MAXC)), 1, 0);
      step(1, 77, 1, 1); step(1, 78, 1, 1);
      rand_cycles(40, 0);
      // Random pdb drops while streaming
      rand_cycles(400, 25);
      step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
